nr_recip_ctrl: RTL and testbench
================================

NR_RECIP_CTRL -- requirements
Module: nr_recip_ctrl

Interface
REQ-001 Parameter ITER_W, default 4, width of the iteration-count input and counter.
REQ-002 Parameter DIV_EN, default 1; when 1 the divide mode with a final quotient multiply is supported, and when 0 div_mode is ignored and treated as 0.
REQ-003 clock  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req  in  1  request; four-phase handshake with ack.
REQ-006 div_mode  in  1  0 = reciprocal 1/d, 1 = quotient n/d; sampled with req.
REQ-007 n_iter  in  ITER_W  Newton-Raphson iteration count; sampled with req.
REQ-008 zero_in  in  1  datapath flag, divisor == 0; sampled with req.
REQ-009 abort  in  1  cancel the current operation.
REQ-010 mult_ready  in  1  multiplier result valid; honoured only in WAIT states.
REQ-011 mult_start  out  1  one-cycle multiplier launch pulse.
REQ-012 sel_a  out  2  operand-A mux: 0 = d, 1 = x.
REQ-013 sel_b  out  2  operand-B mux: 0 = x, 1 = (2 - t), 2 = numerator.
REQ-014 init_load  out  1  datapath latches d, numerator and x0.
REQ-015 t_load / x_load / q_load  out  1 each  register write strobes.
REQ-016 ack  out  1  done; held until req falls.
REQ-017 err  out  1  divide-by-zero; valid while ack = 1.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 iter_cnt  out  ITER_W  completed iterations.

Function
REQ-020 The state machine SHALL have the states IDLE, INIT, M1_ISSUE, M1_WAIT, M2_ISSUE, M2_WAIT, FIN_ISSUE, FIN_WAIT and DONE, with unreachable encodings going to IDLE.
REQ-021 In IDLE, req = 1 and zero_in = 1 SHALL cause a move to DONE with err set; req = 1 and zero_in = 0 SHALL latch n_iter and div_mode and cause a move to INIT.
REQ-022 INIT SHALL assert init_load, clear iter_cnt, and go to DONE if n_iter_latched = 0; otherwise it SHALL go to M1_ISSUE.
REQ-023 M1 (t = d*x) SHALL drive sel_a = 0 and sel_b = 0; M2 (x = x*(2 - t)) SHALL drive sel_a = 1 and sel_b = 1; FIN (q = x*n) SHALL drive sel_a = 1 and sel_b = 2; selects SHALL be held for both the ISSUE and WAIT states of each multiply.
REQ-024 ISSUE states SHALL assert mult_start for exactly one cycle and then advance to the matching WAIT state unconditionally; mult_ready in an ISSUE state SHALL be ignored.
REQ-025 WAIT states SHALL stall indefinitely while mult_ready = 0; the strobe for the WAIT state (t_load, x_load or q_load) SHALL be asserted combinationally in the cycle mult_ready = 1 and in no other cycle.
REQ-026 M1_WAIT SHALL go to M2_ISSUE on mult_ready.
REQ-027 M2_WAIT on mult_ready SHALL increment iter_cnt; if the incremented value equals n_iter_latched it SHALL go to FIN_ISSUE when div_mode = 1 and to DONE when div_mode = 0, and otherwise to M1_ISSUE.
REQ-028 FIN_WAIT SHALL go to DONE on mult_ready.
REQ-029 DONE SHALL assert ack and hold err; it SHALL return to IDLE in the cycle after req = 0 is sampled and clear ack and err on that return.
REQ-030 With mult_ready high in the first WAIT cycle, ack SHALL rise 4k+2 cycles after the sampling edge in reciprocal mode and 4k+4 cycles after it in divide mode, where k = n_iter.
REQ-031 abort = 1 in any state other than IDLE or DONE SHALL force IDLE on the next edge with no ack and no strobe; abort SHALL take priority over mult_ready in the same cycle.
REQ-032 n_iter and div_mode changes after sampling SHALL have no effect until the next request.

Reset
REQ-033 reset SHALL force IDLE, and outputs SHALL be 0 from the next edge.
REQ-034 reset SHALL dominate abort, req and mult_ready in the same cycle, including mid-operation, and no strobe SHALL be issued in the reset cycle.

Structure
REQ-035 A package nr_pkg SHALL hold the state enum, the sel_a/sel_b encodings and the default ITER_W.
REQ-036 A single sub-module, nr_iter_counter, SHALL implement iter_cnt with clear, increment and the terminal-compare output.

Verification
REQ-037 A bench SHALL check: reset; req=1, zero_in=0, n_iter=3, div_mode=0, mult_ready high in every WAIT cycle -> ack rises at +14 cycles, x_load pulses 3 times, iter_cnt = 3.
REQ-038 A bench SHALL check: same as REQ-037 with div_mode=1 -> one q_load with sel_a=1, sel_b=2, and ack at +16 cycles.
REQ-039 A bench SHALL check: req with zero_in=1 -> ack=1 and err=1 one cycle later, with no mult_start.
REQ-040 A bench SHALL check: n_iter=0 with div_mode=0 -> INIT then DONE, with no mult_start and iter_cnt = 0.
REQ-041 A bench SHALL check: mult_ready delayed 5 cycles in M2_WAIT, then abort asserted in the same cycle as mult_ready -> no x_load, IDLE next cycle, ack = 0.
REQ-042 A bench SHALL check: reset asserted in M1_WAIT -> IDLE and all outputs 0; req held high after ack -> ack stays 1 until req falls.

Source files
------------

// File: rtl/nr_pkg.sv
// ---------------------------------------------------------------------------
// nr_pkg
// Shared definitions for the Newton-Raphson reciprocal/divide controller:
//   - nr_state_t      : controller state encoding
//   - SEL_A_* / SEL_B_*: operand mux select codes driven to the datapath
//   - NR_ITER_W       : default width of the iteration count
// ---------------------------------------------------------------------------
package nr_pkg;

    localparam int NR_ITER_W = 4;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_INIT      = 4'd1,
        ST_M1_ISSUE  = 4'd2,
        ST_M1_WAIT   = 4'd3,
        ST_M2_ISSUE  = 4'd4,
        ST_M2_WAIT   = 4'd5,
        ST_FIN_ISSUE = 4'd6,
        ST_FIN_WAIT  = 4'd7,
        ST_DONE      = 4'd8
    } nr_state_t;

    // Operand A: divisor d or current estimate x
    localparam logic [1:0] SEL_A_D = 2'd0;
    localparam logic [1:0] SEL_A_X = 2'd1;

    // Operand B: estimate x, correction (2 - t) or numerator
    localparam logic [1:0] SEL_B_X           = 2'd0;
    localparam logic [1:0] SEL_B_TWO_MINUS_T = 2'd1;
    localparam logic [1:0] SEL_B_NUM         = 2'd2;

endpackage

// File: rtl/nr_iter_counter.sv
// ---------------------------------------------------------------------------
// nr_iter_counter
// Counts completed Newton-Raphson iterations and flags when the next
// increment will reach the requested iteration count.
//   clock, reset : clock and synchronous active-high reset
//   clear        : zero the count (start of an operation)
//   inc          : one iteration has completed
//   limit        : requested iteration count
//   count        : completed iterations
//   last         : count + 1 == limit (the pending increment is the final one)
// ---------------------------------------------------------------------------
module nr_iter_counter
    import nr_pkg::*;
#(
    parameter int ITER_W = NR_ITER_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              inc,
    input  logic [ITER_W-1:0] limit,
    output logic [ITER_W-1:0] count,
    output logic              last
);

    logic [ITER_W-1:0] count_next;

    assign count_next = count + ITER_W'(1);

    // Compare against the incremented value so the controller can decide
    // the next state in the same cycle the iteration completes.
    assign last = (count_next == limit);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/nr_recip_ctrl.sv
// ---------------------------------------------------------------------------
// nr_recip_ctrl
// Sequencer for a Newton-Raphson reciprocal (1/d) or quotient (n/d) unit
// built around one shared multiplier. Each iteration runs t = d*x followed
// by x = x*(2 - t); divide mode adds a final q = x*n.
//   clock, reset         : clock and synchronous active-high reset
//   req / ack            : four-phase request handshake
//   div_mode, n_iter,
//   zero_in              : operation parameters, sampled with req
//   abort                : cancel the operation in flight
//   mult_ready           : multiplier result valid
//   mult_start           : one-cycle multiplier launch
//   sel_a, sel_b         : operand mux selects
//   init_load            : datapath loads d, numerator and x0
//   t_load/x_load/q_load : result register write strobes
//   err                  : divide by zero, valid with ack
//   busy                 : controller not idle
//   iter_cnt             : completed iterations
// ---------------------------------------------------------------------------
module nr_recip_ctrl
    import nr_pkg::*;
#(
    parameter int ITER_W = NR_ITER_W,
    parameter bit DIV_EN = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              div_mode,
    input  logic [ITER_W-1:0] n_iter,
    input  logic              zero_in,
    input  logic              abort,
    input  logic              mult_ready,
    output logic              mult_start,
    output logic [1:0]        sel_a,
    output logic [1:0]        sel_b,
    output logic              init_load,
    output logic              t_load,
    output logic              x_load,
    output logic              q_load,
    output logic              ack,
    output logic              err,
    output logic              busy,
    output logic [ITER_W-1:0] iter_cnt
);

    nr_state_t         state;
    logic [ITER_W-1:0] n_iter_q;
    logic              div_q;
    logic              zero_q;
    logic              quiet;
    logic              cnt_clear;
    logic              cnt_inc;
    logic              cnt_last;

    // Reset or abort in the current cycle suppresses every strobe, so the
    // datapath never sees a write from an operation being torn down.
    assign quiet = reset | abort;

    assign busy      = (state != ST_IDLE);
    assign cnt_clear = (state == ST_INIT) && !abort;
    assign cnt_inc   = (state == ST_M2_WAIT) && mult_ready && !quiet;

    nr_iter_counter #(
        .ITER_W (ITER_W)
    ) u_iter_counter (
        .clock (clock),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .limit (n_iter_q),
        .count (iter_cnt),
        .last  (cnt_last)
    );

    // Selects are held across both ISSUE and WAIT of a multiply; strobes
    // follow mult_ready combinationally so the result is captured the
    // cycle it appears.
    always_comb begin
        mult_start = 1'b0;
        init_load  = 1'b0;
        t_load     = 1'b0;
        x_load     = 1'b0;
        q_load     = 1'b0;
        sel_a      = SEL_A_D;
        sel_b      = SEL_B_X;
        case (state)
            ST_INIT:      init_load = !quiet;
            ST_M1_ISSUE:  mult_start = !quiet;
            ST_M1_WAIT:   t_load = mult_ready && !quiet;
            ST_M2_ISSUE: begin
                sel_a      = SEL_A_X;
                sel_b      = SEL_B_TWO_MINUS_T;
                mult_start = !quiet;
            end
            ST_M2_WAIT: begin
                sel_a  = SEL_A_X;
                sel_b  = SEL_B_TWO_MINUS_T;
                x_load = mult_ready && !quiet;
            end
            ST_FIN_ISSUE: begin
                sel_a      = SEL_A_X;
                sel_b      = SEL_B_NUM;
                mult_start = !quiet;
            end
            ST_FIN_WAIT: begin
                sel_a  = SEL_A_X;
                sel_b  = SEL_B_NUM;
                q_load = mult_ready && !quiet;
            end
            default: ;
        endcase
    end

    // Main sequencer. ack and err are raised from inside DONE, so ack rises
    // one cycle after DONE is entered and drops on the edge that leaves it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            n_iter_q <= '0;
            div_q    <= 1'b0;
            zero_q   <= 1'b0;
            ack      <= 1'b0;
            err      <= 1'b0;
        end else if (abort && (state != ST_IDLE) && (state != ST_DONE)) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        n_iter_q <= n_iter;
                        div_q    <= div_mode & DIV_EN;
                        zero_q   <= zero_in;
                        state    <= zero_in ? ST_DONE : ST_INIT;
                    end
                end
                ST_INIT:      state <= (n_iter_q == '0) ? ST_DONE : ST_M1_ISSUE;
                ST_M1_ISSUE:  state <= ST_M1_WAIT;
                ST_M1_WAIT: begin
                    if (mult_ready) state <= ST_M2_ISSUE;
                end
                ST_M2_ISSUE:  state <= ST_M2_WAIT;
                ST_M2_WAIT: begin
                    if (mult_ready) begin
                        if (cnt_last) state <= div_q ? ST_FIN_ISSUE : ST_DONE;
                        else          state <= ST_M1_ISSUE;
                    end
                end
                ST_FIN_ISSUE: state <= ST_FIN_WAIT;
                ST_FIN_WAIT: begin
                    if (mult_ready) state <= ST_DONE;
                end
                ST_DONE: begin
                    if (!req) begin
                        state <= ST_IDLE;
                        ack   <= 1'b0;
                        err   <= 1'b0;
                    end else begin
                        ack <= 1'b1;
                        err <= zero_q;
                    end
                end
                default:      state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nr_recip_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nr_recip_ctrl
// Self-checking bench for nr_recip_ctrl. A behavioural model describes each
// operation as a list of multiplies (t, x per iteration, then q in divide
// mode) and is compared against the DUT on every falling edge. Directed
// scenarios pin the model with hand-computed latencies and strobe counts;
// a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_nr_recip_ctrl;

    localparam int OP_T = 0;
    localparam int OP_X = 1;
    localparam int OP_Q = 2;

    localparam int M_IDLE = 0;
    localparam int M_INIT = 1;
    localparam int M_RUN  = 2;
    localparam int M_DONE = 3;

    logic       clock;
    logic       reset;
    logic       req;
    logic       div_mode;
    logic [3:0] n_iter;
    logic       zero_in;
    logic       abort;
    logic       mult_ready;
    logic       mult_start;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic       init_load;
    logic       t_load;
    logic       x_load;
    logic       q_load;
    logic       ack;
    logic       err;
    logic       busy;
    logic [3:0] iter_cnt;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    nr_recip_ctrl #(
        .ITER_W (4),
        .DIV_EN (1'b1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .div_mode   (div_mode),
        .n_iter     (n_iter),
        .zero_in    (zero_in),
        .abort      (abort),
        .mult_ready (mult_ready),
        .mult_start (mult_start),
        .sel_a      (sel_a),
        .sel_b      (sel_b),
        .init_load  (init_load),
        .t_load     (t_load),
        .x_load     (x_load),
        .q_load     (q_load),
        .ack        (ack),
        .err        (err),
        .busy       (busy),
        .iter_cnt   (iter_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard stop in case a wait goes wrong somewhere unexpected.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assert_cnt++;
        if (actual !== expected) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // -----------------------------------------------------------------------
    // Behavioural model: operation = queue of pending multiplies
    // -----------------------------------------------------------------------
    int         m_mode     = M_IDLE;
    int         op_q[$];
    bit         m_launched = 1'b0;
    logic       m_ack      = 1'b0;
    logic       m_err      = 1'b0;
    logic       m_err_pend = 1'b0;
    logic [3:0] m_cnt      = 4'd0;

    logic       e_ms, e_il, e_t, e_x, e_q, quiet_m, chk_sel;
    logic [1:0] e_sa, e_sb;

    always @(negedge clock) begin
        quiet_m = reset || abort;
        e_ms = 1'b0; e_il = 1'b0; e_t = 1'b0; e_x = 1'b0; e_q = 1'b0;
        e_sa = 2'd0; e_sb = 2'd0; chk_sel = 1'b0;
        if (m_mode == M_INIT) e_il = !quiet_m;
        if (m_mode == M_RUN) begin
            chk_sel = 1'b1;
            case (op_q[0])
                OP_T:    begin e_sa = 2'd0; e_sb = 2'd0; end
                OP_X:    begin e_sa = 2'd1; e_sb = 2'd1; end
                default: begin e_sa = 2'd1; e_sb = 2'd2; end
            endcase
            if (!m_launched) e_ms = !quiet_m;
            else begin
                e_t = (op_q[0] == OP_T) && mult_ready && !quiet_m;
                e_x = (op_q[0] == OP_X) && mult_ready && !quiet_m;
                e_q = (op_q[0] == OP_Q) && mult_ready && !quiet_m;
            end
        end

        checkOutput("busy", busy, m_mode != M_IDLE);
        checkOutput("ack", ack, m_ack);
        checkOutput("err", err, m_err);
        checkOutput("iter_cnt", iter_cnt, m_cnt);
        checkOutput("mult_start", mult_start, e_ms);
        checkOutput("init_load", init_load, e_il);
        checkOutput("t_load", t_load, e_t);
        checkOutput("x_load", x_load, e_x);
        checkOutput("q_load", q_load, e_q);
        if (chk_sel) begin
            checkOutput("sel_a", sel_a, e_sa);
            checkOutput("sel_b", sel_b, e_sb);
        end

        // Advance the model to what the coming rising edge produces.
        if (reset) begin
            m_mode = M_IDLE; m_ack = 1'b0; m_err = 1'b0; m_cnt = 4'd0;
            op_q.delete();
        end else begin
            case (m_mode)
                M_IDLE: if (req) begin
                    if (zero_in) begin
                        m_err_pend = 1'b1;
                        m_mode = M_DONE;
                    end else begin
                        m_err_pend = 1'b0;
                        op_q.delete();
                        for (int i = 0; i < int'(n_iter); i++) begin
                            op_q.push_back(OP_T);
                            op_q.push_back(OP_X);
                        end
                        if (n_iter != 4'd0 && div_mode) op_q.push_back(OP_Q);
                        m_mode = M_INIT;
                    end
                end
                M_INIT: if (abort) m_mode = M_IDLE;
                else begin
                    m_cnt = 4'd0;
                    m_launched = 1'b0;
                    m_mode = (op_q.size() == 0) ? M_DONE : M_RUN;
                end
                M_RUN: if (abort) m_mode = M_IDLE;
                else if (!m_launched) m_launched = 1'b1;
                else if (mult_ready) begin
                    if (op_q[0] == OP_X) m_cnt = m_cnt + 4'd1;
                    void'(op_q.pop_front());
                    m_launched = 1'b0;
                    if (op_q.size() == 0) m_mode = M_DONE;
                end
                default: if (!req) begin
                    m_mode = M_IDLE; m_ack = 1'b0; m_err = 1'b0;
                end else begin
                    m_ack = 1'b1; m_err = m_err_pend;
                end
            endcase
        end
    end

    // Strobe tallies for the directed scenarios.
    int   ms_cnt, il_cnt, t_cnt, x_cnt, q_cnt;
    logic [1:0] q_sa, q_sb;

    always @(negedge clock) begin
        if (mult_start) ms_cnt++;
        if (init_load)  il_cnt++;
        if (t_load)     t_cnt++;
        if (x_load)     x_cnt++;
        if (q_load) begin
            q_cnt++;
            q_sa = sel_a;
            q_sb = sel_b;
        end
    end

    task automatic clearCounts();
        ms_cnt = 0; il_cnt = 0; t_cnt = 0; x_cnt = 0; q_cnt = 0;
        q_sa = 2'd3; q_sb = 2'd3;
    endtask

    // Counts cycles from the sampling edge until ack is seen.
    task automatic waitAck(output int cycles);
        cycles = 0;
        for (int c = 0; c < 200; c++) begin
            step();
            cycles++;
            if (ack) break;
        end
        if (!ack) checkOutput("ack_timeout", 0, 1);
    endtask

    task automatic releaseReq();
        req = 1'b0;
        step();
        checkOutput("release_ack", ack, 0);
        checkOutput("release_busy", busy, 0);
    endtask

    // One randomized operation with noisy inputs after the sampling edge.
    task automatic applyStimulus(input logic [3:0] k, input logic div, input logic zero);
        bit done;
        bit aborted;
        req = 1'b1; n_iter = k; div_mode = div; zero_in = zero; abort = 1'b0;
        mult_ready = ($urandom_range(0, 1) == 1);
        step();
        done = 1'b0; aborted = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            mult_ready = ($urandom_range(0, 2) != 0);
            n_iter     = 4'($urandom);
            div_mode   = 1'($urandom);
            zero_in    = 1'($urandom);
            abort      = ($urandom_range(0, 49) == 0);
            step();
            if (ack) done = 1'b1;
            else if (!busy) begin done = 1'b1; aborted = 1'b1; end
        end
        abort = 1'b0;
        if (!done) checkOutput("txn_timeout", 0, 1);
        if (!aborted) repeat ($urandom_range(0, 3)) step();
        req = 1'b0;
        for (int c = 0; c < 10 && busy; c++) step();
        if (busy) checkOutput("idle_timeout", 0, 1);
    endtask

    int lat;

    initial begin
        reset = 1'b1; req = 1'b0; div_mode = 1'b0; n_iter = 4'd0;
        zero_in = 1'b0; abort = 1'b0; mult_ready = 1'b0;
        clearCounts();
        step();
        step();
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_ack", ack, 0);
        checkOutput("reset_iter_cnt", iter_cnt, 0);
        reset = 1'b0;
        step();

        // Reciprocal, 3 iterations; parameters change after sampling.
        $display("[TB] reciprocal n_iter=3");
        clearCounts();
        req = 1'b1; n_iter = 4'd3; div_mode = 1'b0; mult_ready = 1'b1;
        step();
        n_iter = 4'd7; div_mode = 1'b1;
        waitAck(lat);
        checkOutput("recip_latency", lat, 14);
        checkOutput("recip_x_loads", x_cnt, 3);
        checkOutput("recip_t_loads", t_cnt, 3);
        checkOutput("recip_q_loads", q_cnt, 0);
        checkOutput("recip_iter_cnt", iter_cnt, 3);
        checkOutput("recip_err", err, 0);
        releaseReq();

        // Divide, 3 iterations.
        $display("[TB] divide n_iter=3");
        clearCounts();
        req = 1'b1; n_iter = 4'd3; div_mode = 1'b1; mult_ready = 1'b1;
        step();
        div_mode = 1'b0;
        waitAck(lat);
        checkOutput("div_latency", lat, 16);
        checkOutput("div_q_loads", q_cnt, 1);
        checkOutput("div_q_sel_a", q_sa, 1);
        checkOutput("div_q_sel_b", q_sb, 2);
        checkOutput("div_x_loads", x_cnt, 3);
        checkOutput("div_mult_starts", ms_cnt, 7);
        releaseReq();

        // Divide by zero.
        $display("[TB] zero divisor");
        clearCounts();
        req = 1'b1; n_iter = 4'd3; zero_in = 1'b1;
        step();
        zero_in = 1'b0;
        step();
        checkOutput("zero_ack", ack, 1);
        checkOutput("zero_err", err, 1);
        checkOutput("zero_mult_starts", ms_cnt, 0);
        releaseReq();

        // Zero iterations.
        $display("[TB] n_iter=0");
        clearCounts();
        req = 1'b1; n_iter = 4'd0; div_mode = 1'b0;
        step();
        waitAck(lat);
        checkOutput("n0_latency", lat, 2);
        checkOutput("n0_mult_starts", ms_cnt, 0);
        checkOutput("n0_init_loads", il_cnt, 1);
        checkOutput("n0_iter_cnt", iter_cnt, 0);
        releaseReq();

        // Stall in M2_WAIT, then abort together with mult_ready.
        $display("[TB] abort with mult_ready");
        clearCounts();
        req = 1'b1; n_iter = 4'd2; div_mode = 1'b0; mult_ready = 1'b1;
        repeat (4) step();
        mult_ready = 1'b0;
        step();
        repeat (5) step();
        mult_ready = 1'b1; abort = 1'b1;
        step();
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_ack", ack, 0);
        checkOutput("abort_x_loads", x_cnt, 0);
        checkOutput("abort_t_loads", t_cnt, 1);
        req = 1'b0; abort = 1'b0; mult_ready = 1'b0;
        step();

        // Reset in M1_WAIT, racing abort and mult_ready.
        $display("[TB] reset mid-operation");
        clearCounts();
        req = 1'b1; n_iter = 4'd2; mult_ready = 1'b0;
        repeat (3) step();
        reset = 1'b1; mult_ready = 1'b1; abort = 1'b1;
        step();
        checkOutput("rst_t_loads", t_cnt, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_ack", ack, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_iter_cnt", iter_cnt, 0);
        checkOutput("rst_mult_start", mult_start, 0);
        checkOutput("rst_init_load", init_load, 0);
        reset = 1'b0; abort = 1'b0; req = 1'b0; mult_ready = 1'b0;
        step();

        // ack held while req stays high.
        $display("[TB] req held after ack");
        req = 1'b1; n_iter = 4'd1; div_mode = 1'b0; mult_ready = 1'b1;
        step();
        waitAck(lat);
        checkOutput("hold_latency", lat, 6);
        for (int i = 0; i < 8; i++) begin
            step();
            checkOutput("hold_ack", ack, 1);
        end
        releaseReq();

        // Randomized operations.
        $display("[TB] random phase");
        for (int t = 0; t < 40; t++) begin
            applyStimulus((t % 10 == 9) ? 4'd15 : 4'($urandom_range(0, 6)),
                          1'($urandom), ($urandom_range(0, 7) == 0));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
